dcache_2way_wb: RTL and testbench



---
 rtl/dcache_2way_wb.sv | 195 +++++++++++++++++++
 tb/tb_dcache_2way_wb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_2way_wb.sv
// 2-way set-associative write-back, write-allocate data cache with one word per line and 1-bit LRU.
// Define DCACHE_STATS_EN to add the hit_cnt/miss_cnt counters and ports.
module dcache_2way_wb #(
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS      = 2 ** INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, WB, RM} state_t;
  state_t state, state_next;

  logic [SETS-1:0]      valid [2];
  logic [SETS-1:0]      dirty [2];
  logic [SETS-1:0]      lru;
  logic [TAG_WIDTH-1:0] tag_mem  [2][SETS];
  logic [31:0]          data_mem [2][SETS];

  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        victim_lat;
  logic        addr_rcv;

  logic [INDEX_WIDTH-1:0] idx, l_idx;
  logic [TAG_WIDTH-1:0]   tag_in, l_tag;
  logic                   hit0, hit1, hit, hit_way, victim;
  logic [31:0]            hit_line;
  logic                   accept, hit_accept, miss_accept, refill_done;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    byte_mask = 4'b0001 << off;
      2'd1:    byte_mask = off[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] line, input logic [31:0] wdata,
                                        input logic [3:0] mask);
    merge = line;
    for (int i = 0; i < 4; i++)
      if (mask[i]) merge[8*i +: 8] = wdata[8*i +: 8];
  endfunction

  assign idx    = cpu_data_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign tag_in = cpu_data_addr[31:INDEX_WIDTH+OFFSET_WIDTH];
  assign l_idx  = req_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign l_tag  = req_addr[31:INDEX_WIDTH+OFFSET_WIDTH];

  // Way0 wins if both ways ever match; victim prefers an empty way before the LRU one.
  assign hit0     = valid[0][idx] && (tag_mem[0][idx] == tag_in);
  assign hit1     = valid[1][idx] && (tag_mem[1][idx] == tag_in);
  assign hit      = hit0 || hit1;
  assign hit_way  = !hit0;
  assign hit_line = hit_way ? data_mem[1][idx] : data_mem[0][idx];
  assign victim   = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);

  assign accept      = (state == IDLE) && cpu_data_req && !rst;
  assign hit_accept  = accept && hit;
  assign miss_accept = accept && !hit;
  assign refill_done = (state == RM) && cache_data_data_ok && !rst;

  assign cache_data_size = 2'b10;

  always_comb begin
    state_next       = state;
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = hit_line;
    cache_data_req   = 1'b0;
    cache_data_wr    = 1'b0;
    cache_data_addr  = {l_tag, l_idx, {OFFSET_WIDTH{1'b0}}};
    cache_data_wdata = data_mem[victim_lat][l_idx];
    case (state)
      IDLE: begin
        cpu_data_addr_ok = cpu_data_req;
        cpu_data_data_ok = cpu_data_req && hit;
        if (cpu_data_req && !hit)
          state_next = (valid[victim][idx] && dirty[victim][idx]) ? WB : RM;
      end
      WB: begin
        cache_data_req  = !addr_rcv;
        cache_data_wr   = 1'b1;
        cache_data_addr = {tag_mem[victim_lat][l_idx], l_idx, {OFFSET_WIDTH{1'b0}}};
        if (cache_data_data_ok) state_next = RM;
      end
      RM: begin
        cache_data_req   = !addr_rcv;
        cpu_data_rdata   = cache_data_rdata;
        cpu_data_data_ok = cache_data_data_ok;
        if (cache_data_data_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      cpu_data_addr_ok = 1'b0;
      cpu_data_data_ok = 1'b0;
      cache_data_req   = 1'b0;
    end
  end

  // addr_rcv suppresses req between the address handshake and data_ok.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_rcv <= 1'b0;
    end else begin
      state <= state_next;
      if (state != IDLE) begin
        if (cache_data_data_ok)                      addr_rcv <= 1'b0;
        else if (cache_data_req && cache_data_addr_ok) addr_rcv <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (miss_accept) begin
      req_wr     <= cpu_data_wr;
      req_size   <= cpu_data_size;
      req_addr   <= cpu_data_addr;
      req_wdata  <= cpu_data_wdata;
      victim_lat <= victim;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru      <= '0;
    end else if (hit_accept) begin
      lru[idx] <= ~hit_way;
      if (cpu_data_wr) dirty[hit_way][idx] <= 1'b1;
    end else if (refill_done) begin
      valid[victim_lat][l_idx] <= 1'b1;
      dirty[victim_lat][l_idx] <= req_wr;
      lru[l_idx]               <= ~victim_lat;
    end
  end

  // Refill writes only use the latched index/tag, never the live core address.
  always_ff @(posedge clk) begin
    if (hit_accept && cpu_data_wr) begin
      data_mem[hit_way][idx] <= merge(hit_line, cpu_data_wdata,
                                      byte_mask(cpu_data_size, cpu_data_addr[1:0]));
    end else if (refill_done) begin
      tag_mem[victim_lat][l_idx]  <= l_tag;
      data_mem[victim_lat][l_idx] <= req_wr ?
        merge(cache_data_rdata, req_wdata, byte_mask(req_size, req_addr[1:0])) :
        cache_data_rdata;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_accept)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss_accept) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_2way_wb.sv
// Directed scoreboard bench for dcache_2way_wb with a behavioural sram-like bridge model.
module tb_dcache_2way_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_data_req;
  logic        cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr;
  logic [31:0] cpu_data_wdata;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata;
  logic        cache_data_addr_ok;
  logic        cache_data_data_ok;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        txn_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          addr_delay = 0;
  int          data_delay = 1;
  int          req_violations = 0;
  int          passed = 0;
  int          total = 0;

  dcache_2way_wb dut (
    .clk(clk), .rst(rst),
    .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr),
    .cpu_data_size(cpu_data_size), .cpu_data_addr(cpu_data_addr),
    .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata),
    .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
    .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr),
    .cache_data_size(cache_data_size), .cache_data_addr(cache_data_addr),
    .cache_data_wdata(cache_data_wdata), .cache_data_rdata(cache_data_rdata),
    .cache_data_addr_ok(cache_data_addr_ok), .cache_data_data_ok(cache_data_data_ok)
`ifdef DCACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] storeMerge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] keep;
    case (size)
      2'd0:    keep = ~(32'hFF << (8 * off));
      2'd1:    keep = off[1] ? 32'h0000FFFF : 32'hFFFF0000;
      default: keep = 32'h0;
    endcase
    return (old & keep) | (wd & ~keep);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  task automatic checkRead();
    logic [31:0] e;
    checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("rdata", cpu_data_rdata, e);
    end
  endtask

  task automatic expectTxn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    checkOutput("txn_present", 32'(txn_q.size() != 0), 32'd1);
    if (txn_q.size() != 0) begin
      t = txn_q.pop_front();
      checkOutput("txn_wr", 32'(t.wr), 32'(wr));
      checkOutput("txn_addr", t.addr, addr);
      if (wr) checkOutput("txn_wdata", t.wdata, wdata);
    end
  endtask

  task automatic expectNoTxn();
    checkOutput("txn_count", 32'(txn_q.size()), 32'd0);
  endtask

  // One core access; on a miss the request is held high to prove nothing else is accepted.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic exp_hit);
    logic [31:0] word;
    logic        seen;
    int          blocked;
    word = {addr[31:2], 2'b00};
    @(negedge clk);
    cpu_data_req   = 1'b1;
    cpu_data_wr    = wr;
    cpu_data_size  = size;
    cpu_data_addr  = addr;
    cpu_data_wdata = wdata;
    if (!wr) exp_q.push_back(refRead(word));
    else     ref_mem[word] = storeMerge(refRead(word), wdata, size, addr[1:0]);
    #1;
    checkOutput("addr_ok", 32'(cpu_data_addr_ok), 32'd1);
    checkOutput("hit_data_ok", 32'(cpu_data_data_ok), 32'(exp_hit));
    if (cpu_data_data_ok) begin
      if (!wr) checkRead();
      @(posedge clk);
      #1 cpu_data_req = 1'b0;
    end else begin
      seen    = 1'b0;
      blocked = 0;
      @(posedge clk);
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        #1;
        if (cpu_data_addr_ok) blocked++;
        if (cpu_data_data_ok) begin
          seen = 1'b1;
          if (!wr) checkRead();
        end
      end
      @(posedge clk);
      #1 cpu_data_req = 1'b0;
      checkOutput("miss_done", 32'(seen), 32'd1);
      checkOutput("no_accept_in_miss", 32'(blocked), 32'd0);
    end
  endtask

  task automatic respond(input txn_t t);
    if (t.wr) mem[t.addr] = t.wdata;
    else      cache_data_rdata = memRead(t.addr);
    cache_data_data_ok = 1'b1;
  endtask

  // Bridge model: addr_ok after addr_delay waiting cycles, data_ok data_delay cycles later.
  initial begin
    txn_t t;
    int   wait_cycles;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    cache_data_rdata   = 32'h0;
    wait_cycles        = 0;
    forever begin
      @(negedge clk);
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      if (rst) begin
        wait_cycles = 0;
      end else if (!cache_data_req) begin
        if (wait_cycles > 0) req_violations++;
        wait_cycles = 0;
      end else if (wait_cycles < addr_delay) begin
        wait_cycles++;
      end else begin
        wait_cycles = 0;
        t.wr    = cache_data_wr;
        t.addr  = cache_data_addr;
        t.wdata = cache_data_wdata;
        txn_q.push_back(t);
        cache_data_addr_ok = 1'b1;
        if (data_delay == 0) begin
          respond(t);
        end else begin
          for (int k = 1; k <= data_delay; k++) begin
            @(negedge clk);
            cache_data_addr_ok = 1'b0;
            if (rst) break;
            if (cache_data_req) req_violations++;
            if (k == data_delay) respond(t);
          end
        end
      end
    end
  end

  initial begin
    mem[32'h100]  = 32'hDEADBEEF;
    mem[32'h500]  = 32'h55555555;
    mem[32'h900]  = 32'h99999999;
    mem[32'h300]  = 32'h33333333;
    mem[32'h1C00] = 32'h1C1C1C1C;
    mem[32'h2C00] = 32'h2C2C2C2C;
    foreach (mem[a]) ref_mem[a] = mem[a];

    rst = 1'b1;
    cpu_data_req   = 1'b1;
    cpu_data_wr    = 1'b0;
    cpu_data_size  = 2'd2;
    cpu_data_addr  = 32'h100;
    cpu_data_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_addr_ok", 32'(cpu_data_addr_ok), 32'd0);
    checkOutput("rst_data_ok", 32'(cpu_data_data_ok), 32'd0);
    checkOutput("rst_mem_req", 32'(cache_data_req), 32'd0);
    rst = 1'b0;
    cpu_data_req = 1'b0;

    // Cold load refills, then hits with zero latency.
    applyStimulus(1'b0, 2'd2, 32'h100, 32'h0, 1'b0);
    expectTxn(1'b0, 32'h100, 32'h0);
    expectNoTxn();
    applyStimulus(1'b0, 2'd2, 32'h100, 32'h0, 1'b1);
    applyStimulus(1'b1, 2'd0, 32'h101, 32'h0000AA00, 1'b1);
    applyStimulus(1'b0, 2'd2, 32'h100, 32'h0, 1'b1);
    expectNoTxn();

    // Second way of the same set, then eviction of the dirty LRU line.
    applyStimulus(1'b0, 2'd2, 32'h500, 32'h0, 1'b0);
    expectTxn(1'b0, 32'h500, 32'h0);
    expectNoTxn();
    applyStimulus(1'b0, 2'd2, 32'h900, 32'h0, 1'b0);
    expectTxn(1'b1, 32'h100, 32'hDEADAAEF);
    expectTxn(1'b0, 32'h900, 32'h0);
    expectNoTxn();
    applyStimulus(1'b1, 2'd1, 32'h502, 32'hBEEF0000, 1'b1);
    applyStimulus(1'b0, 2'd2, 32'h500, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'd2, 32'h900, 32'h0, 1'b1);
    expectNoTxn();

    // Store miss through a slow bridge.
    addr_delay = 5;
    data_delay = 3;
    applyStimulus(1'b1, 2'd2, 32'hC00, 32'h12345678, 1'b0);
    expectTxn(1'b0, 32'hC00, 32'h0);
    expectNoTxn();
    addr_delay = 0;
    data_delay = 1;
    applyStimulus(1'b0, 2'd2, 32'hC00, 32'h0, 1'b1);

    // Same-cycle addr_ok/data_ok; evicting the dirty 0xC00 line proves the store set dirty.
    applyStimulus(1'b0, 2'd2, 32'h1C00, 32'h0, 1'b0);
    expectTxn(1'b0, 32'h1C00, 32'h0);
    data_delay = 0;
    applyStimulus(1'b0, 2'd2, 32'h2C00, 32'h0, 1'b0);
    expectTxn(1'b1, 32'hC00, 32'h12345678);
    expectTxn(1'b0, 32'h2C00, 32'h0);
    expectNoTxn();
    checkOutput("mem_wb_c00", memRead(32'hC00), 32'h12345678);

    // Reset in the middle of a refill aborts it and invalidates everything.
    data_delay = 20;
    @(negedge clk);
    cpu_data_req  = 1'b1;
    cpu_data_wr   = 1'b0;
    cpu_data_size = 2'd2;
    cpu_data_addr = 32'h300;
    @(posedge clk);
    #1 cpu_data_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_data_req  = 1'b1;
    cpu_data_addr = 32'h900;
    #1;
    checkOutput("rst_rm_addr_ok", 32'(cpu_data_addr_ok), 32'd0);
    checkOutput("rst_rm_data_ok", 32'(cpu_data_data_ok), 32'd0);
    checkOutput("rst_rm_mem_req", 32'(cache_data_req), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_data_req = 1'b0;
    data_delay = 1;
    expectTxn(1'b0, 32'h300, 32'h0);
`ifdef DCACHE_STATS_EN
    checkOutput("hit_cnt_rst", hit_cnt, 32'd0);
    checkOutput("miss_cnt_rst", miss_cnt, 32'd0);
`endif
    applyStimulus(1'b0, 2'd2, 32'h100, 32'h0, 1'b0);
    expectTxn(1'b0, 32'h100, 32'h0);
    applyStimulus(1'b0, 2'd2, 32'h100, 32'h0, 1'b1);
    expectNoTxn();
`ifdef DCACHE_STATS_EN
    checkOutput("hit_cnt", hit_cnt, 32'd1);
    checkOutput("miss_cnt", miss_cnt, 32'd1);
`endif

    repeat (2) @(posedge clk);
    checkOutput("req_protocol", 32'(req_violations), 32'd0);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
